// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Round-robin arbiter for the RDI sideband cfg channel: grants one requester at a time,
// serialises its message into MSG_W/NC beats and tracks PHY credits returned on pl_cfg_crd.
module ucie_ctl_sb_tx_arbiter #(
  parameter int NC      = 32,
  parameter int NREQ    = 4,
  parameter int MSG_W   = 64,
  parameter int CRD_MAX = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NREQ-1:0]                i_req_valid,
  input  logic [NREQ*MSG_W-1:0]          i_req_msg,
  output logic [NREQ-1:0]                o_req_ready,
  output logic                           o_rdi_lp_cfg_vld,
  output logic [NC-1:0]                  o_rdi_lp_cfg,
  input  logic                           i_rdi_pl_cfg_crd,
  output logic [$clog2(NREQ)-1:0]        o_grant_id,
  output logic                           o_busy,
  output logic [$clog2(CRD_MAX+1)-1:0]   o_crd_count,
  output logic                           o_crd_err
);

  localparam int BEATS = MSG_W / NC;
  localparam int GW    = $clog2(NREQ);
  localparam int CW    = $clog2(CRD_MAX + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CW-1:0] CRD_FULL  = CW'(CRD_MAX);
  localparam logic [CW-1:0] CRD_NEED  = CW'(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    crd_q, crd_d;
  logic             err_q, err_d;

  logic [GW-1:0]    idx;
  logic [GW-1:0]    pick;
  logic             found;
  logic             grant;
  logic             beat_fire;

  // First valid requester at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = GW'((32'(rr_q) + i) % NREQ);
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign beat_fire = (state_q == SEND);
  assign grant     = (state_q == IDLE) && found && (crd_q >= CRD_NEED) && !i_rst;

  always_comb begin
    o_req_ready = '0;
    if (grant) begin
      o_req_ready[pick] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    msg_d   = msg_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    crd_d   = crd_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = SEND;
          beat_d  = '0;
          msg_d   = i_req_msg[pick*MSG_W +: MSG_W];
          gid_d   = pick;
          rr_d    = (pick == LAST_REQ) ? '0 : pick + 1'b1;
        end
      end
      SEND: begin
        // The latched message shifts down so the current beat is always the low NC bits.
        msg_d  = msg_q >> NC;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_rdi_pl_cfg_crd && !beat_fire) begin
      if (crd_q == CRD_FULL) begin
        err_d = 1'b1;
      end else begin
        crd_d = crd_q + 1'b1;
      end
    end else if (!i_rdi_pl_cfg_crd && beat_fire) begin
      crd_d = crd_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      msg_q   <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
      crd_q   <= CRD_FULL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      msg_q   <= msg_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      crd_q   <= crd_d;
      err_q   <= err_d;
    end
  end

  assign o_rdi_lp_cfg_vld = beat_fire;
  assign o_rdi_lp_cfg     = beat_fire ? msg_q[NC-1:0] : '0;
  assign o_busy           = beat_fire;
  assign o_grant_id       = gid_q;
  assign o_crd_count      = crd_q;
  assign o_crd_err        = err_q;

endmodule
